// File: rtl/exc_ctrl_if.sv
// Pipeline-side connection of the exception controller: MEM-stage requests, CP0 access,
// accept/eret reporting and flush controls.
interface exc_ctrl_if;
  logic [5:0]  i_irq;
  logic        i_MEM_valid;
  logic        i_MEM_exc_valid;
  logic [4:0]  i_MEM_exc_cause;
  logic [31:0] i_MEM_pc;
  logic        i_MEM_is_eret;
  logic        i_mtc0_we;
  logic [4:0]  i_mtc0_addr;
  logic [31:0] i_mtc0_wdata;
  logic [4:0]  i_mfc0_addr;
  logic [31:0] o_mfc0_rdata;
  logic        o_answer_exc;
  logic [4:0]  o_MEM_exception_cause;
  logic        o_MEM_is_eret;
  logic [31:0] o_MEM_epc_value;
  logic        o_flush_IF_ID;
  logic        o_flush_ID_EX;
  logic        o_flush_EX_MEM;
  logic        o_busy;

  modport master (
    output i_irq, i_MEM_valid, i_MEM_exc_valid, i_MEM_exc_cause, i_MEM_pc, i_MEM_is_eret,
    output i_mtc0_we, i_mtc0_addr, i_mtc0_wdata, i_mfc0_addr,
    input  o_mfc0_rdata, o_answer_exc, o_MEM_exception_cause, o_MEM_is_eret, o_MEM_epc_value,
    input  o_flush_IF_ID, o_flush_ID_EX, o_flush_EX_MEM, o_busy
  );

  modport slave (
    input  i_irq, i_MEM_valid, i_MEM_exc_valid, i_MEM_exc_cause, i_MEM_pc, i_MEM_is_eret,
    input  i_mtc0_we, i_mtc0_addr, i_mtc0_wdata, i_mfc0_addr,
    output o_mfc0_rdata, o_answer_exc, o_MEM_exception_cause, o_MEM_is_eret, o_MEM_epc_value,
    output o_flush_IF_ID, o_flush_ID_EX, o_flush_EX_MEM, o_busy
  );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt/eret controller with CP0 Status, Cause and EPC.
// Define EXC_CTRL_IRQ_SYNC_EN to pass i_irq through a 2-flop synchronizer (default: 1 flop).
module exc_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  exc_ctrl_if.slave bus
);

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] AddrSts = 5'd12;
  localparam logic [4:0] AddrCau = 5'd13;
  localparam logic [4:0] AddrEpc = 5'd14;

  typedef enum logic {StRun, StFlush} state_e;

  state_e      state_q;
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [5:0]  ip_q;

  logic       run;
  logic       int_pend;
  logic       exc_acc;
  logic       int_acc;
  logic       eret_acc;
  logic       accept;
  logic       mtc0_ok;
  logic [4:0] code;

`ifdef EXC_CTRL_IRQ_SYNC_EN
  logic [5:0] irq_meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_q <= '0;
      ip_q       <= '0;
    end else begin
      irq_meta_q <= bus.i_irq;
      ip_q       <= irq_meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q <= '0;
    end else begin
      ip_q <= bus.i_irq;
    end
  end
`endif

  // rst_n gates acceptance so every output stays 0 while reset is held.
  assign run      = rst_n && (state_q == StRun);
  assign int_pend = ie_q && !exl_q && (|(ip_q & im_q[7:2]));
  assign exc_acc  = run && bus.i_MEM_exc_valid;
  assign int_acc  = run && !bus.i_MEM_exc_valid && int_pend && bus.i_MEM_valid;
  assign eret_acc = run && !bus.i_MEM_exc_valid && !(int_pend && bus.i_MEM_valid) &&
                    bus.i_MEM_is_eret && bus.i_MEM_valid;
  assign accept   = exc_acc || int_acc || eret_acc;
  assign mtc0_ok  = run && !accept && bus.i_mtc0_we;
  assign code     = exc_acc ? bus.i_MEM_exc_cause : ExcInt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      unique case (state_q)
        StRun:   if (accept) state_q <= StFlush;
        StFlush: state_q <= StRun;
        default: state_q <= StRun;
      endcase
      if (exc_acc || int_acc) begin
        exc_code_q <= code;
        exl_q      <= 1'b1;
        // Nested exceptions keep the original return address.
        if (!exl_q) epc_q <= bus.i_MEM_pc;
      end else if (eret_acc) begin
        exl_q <= 1'b0;
      end else if (mtc0_ok) begin
        if (bus.i_mtc0_addr == AddrSts) begin
          im_q  <= bus.i_mtc0_wdata[15:8];
          exl_q <= bus.i_mtc0_wdata[1];
          ie_q  <= bus.i_mtc0_wdata[0];
        end else if (bus.i_mtc0_addr == AddrEpc) begin
          epc_q <= bus.i_mtc0_wdata;
        end
      end
    end
  end

  always_comb begin
    bus.o_mfc0_rdata = '0;
    if (bus.i_mfc0_addr == AddrSts) begin
      bus.o_mfc0_rdata = {16'h0, im_q, 6'h0, exl_q, ie_q};
    end else if (bus.i_mfc0_addr == AddrCau) begin
      bus.o_mfc0_rdata = {16'h0, ip_q, 3'h0, exc_code_q, 2'h0};
    end else if (bus.i_mfc0_addr == AddrEpc) begin
      bus.o_mfc0_rdata = epc_q;
    end
  end

  assign bus.o_answer_exc          = exc_acc || int_acc;
  assign bus.o_MEM_exception_cause = (exc_acc || int_acc) ? code : 5'd0;
  assign bus.o_MEM_is_eret         = eret_acc;
  assign bus.o_MEM_epc_value       = epc_q;
  assign bus.o_busy                = (state_q == StFlush);
  assign bus.o_flush_IF_ID         = accept || (state_q == StFlush);
  assign bus.o_flush_ID_EX         = accept || (state_q == StFlush);
  assign bus.o_flush_EX_MEM        = accept || (state_q == StFlush);

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: the driver computes expected outputs from a register-level
// model and queues them; an independent monitor compares them against the DUT each cycle.
module tb_exc_ctrl;
`ifdef EXC_CTRL_IRQ_SYNC_EN
  localparam int IrqLat = 2;
`else
  localparam int IrqLat = 1;
`endif

  logic clk;
  logic rst_n;
  exc_ctrl_if bus ();

  exc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        ans;
    logic [4:0]  cause;
    logic        eret;
    logic [31:0] epc;
    logic [2:0]  flush;
    logic        busy;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: Status as a masked word, Cause code, EPC, a flush-cycle flag and the
  // last two sampled irq vectors.
  logic [31:0] m_status = '0;
  logic [31:0] m_epc    = '0;
  logic [4:0]  m_code   = '0;
  logic        m_busy   = 1'b0;
  logic [5:0]  m_irq_d1 = '0;
  logic [5:0]  m_irq_d2 = '0;

  task automatic drive(input logic rst, input logic [5:0] irq, input logic valid,
                       input logic excv, input logic [4:0] cause, input logic [31:0] pc,
                       input logic eret, input logic we, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic [4:0] raddr);
    exp_t e;
    logic [5:0] ip;
    logic [7:0] im;
    logic acc_exc, acc_eret;
    @(negedge clk);
    rst_n               = rst;
    bus.i_irq           = irq;
    bus.i_MEM_valid     = valid;
    bus.i_MEM_exc_valid = excv;
    bus.i_MEM_exc_cause = cause;
    bus.i_MEM_pc        = pc;
    bus.i_MEM_is_eret   = eret;
    bus.i_mtc0_we       = we;
    bus.i_mtc0_addr     = waddr;
    bus.i_mtc0_wdata    = wdata;
    bus.i_mfc0_addr     = raddr;
    e = '0;
    if (!rst) begin
      m_status = '0;
      m_epc    = '0;
      m_code   = '0;
      m_busy   = 1'b0;
      m_irq_d1 = '0;
      m_irq_d2 = '0;
    end else begin
      ip = (IrqLat == 2) ? m_irq_d2 : m_irq_d1;
      im = m_status[15:8];
      acc_exc  = 1'b0;
      acc_eret = 1'b0;
      if (!m_busy) begin
        if (excv) begin
          acc_exc = 1'b1;
          e.cause = cause;
        end else if (m_status[0] && !m_status[1] && ((ip & im[7:2]) != 6'd0) && valid) begin
          acc_exc = 1'b1;
          e.cause = 5'd0;
        end else if (eret && valid) begin
          acc_eret = 1'b1;
        end
      end
      e.ans   = acc_exc;
      e.eret  = acc_eret;
      e.epc   = m_epc;
      e.flush = (acc_exc || acc_eret || m_busy) ? 3'b111 : 3'b000;
      e.busy  = m_busy;
      case (raddr)
        5'd12:   e.rdata = m_status;
        5'd13:   e.rdata = {16'h0, ip, 3'h0, m_code, 2'h0};
        5'd14:   e.rdata = m_epc;
        default: e.rdata = '0;
      endcase
      if (acc_exc) begin
        m_code = e.cause;
        if (!m_status[1]) m_epc = pc;
        m_status[1] = 1'b1;
      end else if (acc_eret) begin
        m_status[1] = 1'b0;
      end else if (!m_busy && we) begin
        if (waddr == 5'd12) m_status = wdata & 32'h0000_ff03;
        else if (waddr == 5'd14) m_epc = wdata;
      end
      m_busy   = acc_exc || acc_eret;
      m_irq_d2 = m_irq_d1;
      m_irq_d1 = irq;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [5:0] irq, input logic [4:0] raddr);
    drive(1'b1, irq, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, raddr);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: samples just before each rising edge, once the driver's inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("answer", 64'({bus.o_answer_exc, bus.o_MEM_exception_cause}),
              64'({e.ans, e.cause}));
        check("eret_epc", 64'({bus.o_MEM_is_eret, bus.o_MEM_epc_value}), 64'({e.eret, e.epc}));
        check("flush_busy", 64'({bus.o_flush_IF_ID, bus.o_flush_ID_EX, bus.o_flush_EX_MEM,
              bus.o_busy}), 64'({e.flush, e.busy}));
        check("mfc0", 64'(bus.o_mfc0_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    logic [5:0]  irq;
    logic [31:0] wd;
    logic [4:0]  wa;
    rst_n = 1'b0;
    drive(1'b0, 6'h3f, 1'b1, 1'b1, 5'd12, 32'h1, 1'b1, 1'b1, 5'd12, 32'hffff, 5'd12);
    drive(1'b0, 6'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14);
    idle(6'h0, 5'd13);
    // Synchronous exception: overflow at 0x00400010.
    drive(1'b1, 6'h0, 1'b1, 1'b1, 5'd12, 32'h0040_0010, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14);
    idle(6'h0, 5'd14);
    idle(6'h0, 5'd12);
    // Interrupt on line 0 with Status = 0x401 (also clears EXL).
    drive(1'b1, 6'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0401, 5'd12);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'h1, 1'b1, 1'b0, 5'd0, 32'h0040_0100 + 32'(i), 1'b0, 1'b0, 5'd0, 32'h0,
            5'd13);
    end
    drive(1'b1, 6'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd12);
    idle(6'h0, 5'd12);
    // Priority: exception, pending interrupt and eret together; then nested exception + eret.
    drive(1'b1, 6'h1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0401, 5'd12);
    idle(6'h1, 5'd12);
    drive(1'b1, 6'h1, 1'b1, 1'b1, 5'd8, 32'h0040_0200, 1'b1, 1'b0, 5'd0, 32'h0, 5'd13);
    idle(6'h0, 5'd12);
    drive(1'b1, 6'h0, 1'b1, 1'b1, 5'd10, 32'h0040_0300, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14);
    idle(6'h0, 5'd14);
    drive(1'b1, 6'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd12);
    idle(6'h0, 5'd12);
    // mtc0 to EPC colliding with an exception is dropped; then reset during FLUSH.
    drive(1'b1, 6'h0, 1'b1, 1'b1, 5'd4, 32'h0040_0400, 1'b0, 1'b1, 5'd14, 32'h1234, 5'd14);
    idle(6'h0, 5'd14);
    drive(1'b1, 6'h0, 1'b1, 1'b1, 5'd13, 32'h0040_0500, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12);
    drive(1'b0, 6'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14);
    idle(6'h0, 5'd12);
    idle(6'h0, 5'd14);

    irq = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) irq = 6'($urandom);
      case ($urandom_range(0, 3))
        0:       wa = 5'd12;
        1:       wa = 5'd13;
        2:       wa = 5'd14;
        default: wa = 5'($urandom);
      endcase
      wd = $urandom;
      drive((i % 250) != 249, irq, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            5'($urandom), $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            wa, wd, 5'($urandom_range(11, 15)));
    end

    @(negedge clk);
    #6;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL provide `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL provide `i_irq`, input, 6 bits: external interrupt lines, level-sensitive.
REQ-004 SHALL provide `i_MEM_valid`, input, 1 bit: MEM holds a real instruction, not a bubble.
REQ-005 SHALL provide `i_MEM_exc_valid`, input, 1 bit, and `i_MEM_exc_cause`, input, 5 bits: a synchronous exception is raised in MEM, with its code.
REQ-006 SHALL provide `i_MEM_pc`, input, 32 bits: PC of the MEM instruction.
REQ-007 SHALL provide `i_MEM_is_eret`, input, 1 bit: MEM holds an eret.
REQ-008 SHALL provide `i_mtc0_we`, input, 1 bit, `i_mtc0_addr`, input, 5 bits, and `i_mtc0_wdata`, input, 32 bits: CP0 write port, driven from MEM.
REQ-009 SHALL provide `i_mfc0_addr`, input, 5 bits, and `o_mfc0_rdata`, output, 32 bits: combinational CP0 read port.
REQ-010 SHALL provide `o_answer_exc`, output, 1 bit, and `o_MEM_exception_cause`, output, 5 bits: exception accepted this cycle, with its code.
REQ-011 SHALL provide `o_MEM_is_eret`, output, 1 bit, and `o_MEM_epc_value`, output, 32 bits: eret accepted this cycle, and the current EPC.
REQ-012 SHALL provide `o_flush_IF_ID`, `o_flush_ID_EX` and `o_flush_EX_MEM`, outputs, 1 bit each: pipeline register flushes.
REQ-013 SHALL provide `o_busy`, output, 1 bit: block is in the FLUSH state.

Function
REQ-014 SHALL use these cause codes: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12, TRAP=13.
REQ-015 SHALL hold three CP0 registers:
- Status (addr 12): IM[15:8], EXL[1], IE[0]; all other bits read 0.
- Cause (addr 13): IP[15:10] (hardware-owned), ExcCode[6:2]; all other bits read 0.
- EPC (addr 14).
- Any other address reads 0.
REQ-016 SHALL define the interrupt-pending condition: `int_pend` = IE & ~EXL & |(IP & IM).
REQ-017 SHALL implement FSM states RUN and FLUSH.
- RUN -> FLUSH on any accept (exception, interrupt or eret).
- FLUSH -> RUN unconditionally after one cycle.
REQ-018 SHALL, in RUN, accept events combinationally (zero latency) with this priority:
1. Synchronous exception (`i_MEM_exc_valid`).
2. Interrupt (`int_pend` & `i_MEM_valid`).
3. eret (`i_MEM_is_eret` & `i_MEM_valid`).
REQ-019 SHALL, on exception/interrupt accept:
- Drive `o_answer_exc`=1 and `o_MEM_exception_cause` = the accepted code (INT for an interrupt).
- At the edge: ExcCode <= code; EXL <= 1; EPC <= `i_MEM_pc` only if EXL was 0.
REQ-020 SHALL, on eret accept, drive `o_MEM_is_eret`=1 and clear EXL at the edge.
REQ-021 SHALL assert all three flush outputs in the accept cycle and again throughout the FLUSH cycle.
REQ-022 SHALL, in FLUSH, force `o_answer_exc`=0 and `o_MEM_is_eret`=0, ignore all requests, and drive `o_busy`=1.
REQ-023 SHALL perform an mtc0 write at the edge when no accept occurs in that cycle and the state is RUN; otherwise the write is dropped.
REQ-024 SHALL update only Status IM/EXL/IE and EPC on mtc0; writes to Cause and to unlisted addresses are ignored.
REQ-025 SHALL drive `o_MEM_epc_value` from the registered EPC, excluding any same-cycle update.
REQ-026 SHALL leave `o_MEM_exception_cause` equal to 0 whenever `o_answer_exc`=0.
REQ-027 SHALL update IP every cycle from the sampled `i_irq` (see REQ-031).

Reset
REQ-028 SHALL, while `rst_n`=0, asynchronously set state=RUN, Status=0, Cause=0, EPC=0 and all `i_irq` sample flops to 0.
REQ-029 SHALL hold every output at 0 during reset.
REQ-030 SHALL abandon a reset asserted during FLUSH, with no residual flush after release.

Configuration
REQ-031 SHALL select `i_irq` sampling with `EXC_CTRL_IRQ_SYNC_EN`:
- Defined: `i_irq` passes a 2-flop synchronizer before IP, giving a 2-cycle `i_irq`->IP latency.
- Undefined: a single register, giving a 1-cycle latency.

Verification
REQ-032 SHALL cover a synchronous exception: RUN, `i_MEM_exc_valid`=1, cause=12, pc=0x00400010 -> `o_answer_exc`=1 and cause 12 same cycle; next cycle EPC=0x00400010, EXL=1, `o_busy`=1; RUN after one cycle.
REQ-033 SHALL cover an interrupt: Status=0x00000401, `i_irq`[0]=1, `i_MEM_valid`=1 -> after the sync latency, `o_answer_exc`=1 with cause 0 and flushes asserted for 2 cycles.
REQ-034 SHALL cover priority: exception, pending interrupt and eret presented together -> exception code reported; eret ignored; EXL=1.
REQ-035 SHALL cover nesting and eret: exception while EXL=1 -> EPC unchanged; a later eret -> `o_MEM_is_eret`=1, `o_MEM_epc_value`=old EPC, EXL cleared.
REQ-036 SHALL cover mtc0 conflict and reset: mtc0 to EPC of 0x1234 in the same cycle as an exception -> write dropped; `rst_n` pulled low during FLUSH -> all registers 0, `o_busy`=0 immediately.
